// File: rtl/write_back_stage.sv
// rtl/write_back_stage.sv - write-back stage with 32 x DATA_W architectural register file
//
// Selects the write-back value from the memory stage and commits it to the
// register file. Two asynchronous read ports serve decode. The current write
// is exported for the forwarding unit. Retired valid instructions are counted.
//
// Optional feature macro: WB_BYPASS_EN
//   defined   : write-first bypass from the committing write to both read ports
//   undefined : read ports return stored register contents only
//
// Ports:
//   clock          in   rising-edge clock
//   reset_n        in   asynchronous active-low reset
//   wb_valid       in   live instruction from the memory stage
//   wb_reg_write   in   instruction writes a register
//   wb_mem_to_reg  in   1 = write mem_data, 0 = write ex_data
//   mem_data       in   load data
//   ex_data        in   ALU result
//   wb_rd          in   destination register index
//   rs_addr        in   read port A index
//   rt_addr        in   read port B index
//   rs_data        out  read port A data (combinational)
//   rt_data        out  read port B data (combinational)
//   fwd_we         out  a register write commits this cycle
//   fwd_rd         out  destination index of that write
//   fwd_data       out  value of that write
//   retired_count  out  number of valid instructions retired (wraps)

module write_back_stage #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              wb_valid,
    input  logic              wb_reg_write,
    input  logic              wb_mem_to_reg,
    input  logic [DATA_W-1:0] mem_data,
    input  logic [DATA_W-1:0] ex_data,
    input  logic [ADDR_W-1:0] wb_rd,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    output logic              fwd_we,
    output logic [ADDR_W-1:0] fwd_rd,
    output logic [DATA_W-1:0] fwd_data,
    output logic [31:0]       retired_count
);

    localparam int NREGS = 1 << ADDR_W;

    logic [DATA_W-1:0] regs_q [NREGS];
    logic [DATA_W-1:0] regs_d [NREGS];
    logic [31:0]       retired_count_q;
    logic [31:0]       retired_count_d;

    logic [DATA_W-1:0] wdata;
    logic              we;

    assign wdata = wb_mem_to_reg ? mem_data : ex_data;

    // Gating with reset_n keeps a write presented during reset from reaching
    // the forwarding unit or the bypass path.
    assign we = reset_n & wb_valid & wb_reg_write & (wb_rd != '0);

    assign fwd_we        = we;
    assign fwd_rd        = wb_rd;
    assign fwd_data      = wdata;
    assign retired_count = retired_count_q;

    always_comb begin
        for (int i = 0; i < NREGS; i++) begin
            regs_d[i] = regs_q[i];
        end
        if (we) begin
            regs_d[wb_rd] = wdata;
        end
        // Register 0 is never stored to, whatever the index logic does.
        regs_d[0] = '0;
    end

    always_comb begin
        retired_count_d = retired_count_q;
        if (wb_valid) begin
            retired_count_d = retired_count_q + 32'd1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
            retired_count_q <= '0;
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
            retired_count_q <= retired_count_d;
        end
    end

    // Read ports resolve independently; index 0 is forced to zero even if a
    // bypass could match, since we already excludes wb_rd == 0.
    always_comb begin
        rs_data = '0;
        rt_data = '0;
        if (reset_n) begin
            if (rs_addr != '0) begin
                rs_data = regs_q[rs_addr];
`ifdef WB_BYPASS_EN
                if (we && (rs_addr == wb_rd)) begin
                    rs_data = wdata;
                end
`endif
            end
            if (rt_addr != '0) begin
                rt_data = regs_q[rt_addr];
`ifdef WB_BYPASS_EN
                if (we && (rt_addr == wb_rd)) begin
                    rt_data = wdata;
                end
`endif
            end
        end
    end

endmodule

// File: tb/tb_write_back_stage.sv
// tb/tb_write_back_stage.sv - directed self-checking bench for write_back_stage
`timescale 1ns/1ps

module tb_write_back_stage;

    logic        clock;
    logic        reset_n;
    logic        wb_valid;
    logic        wb_reg_write;
    logic        wb_mem_to_reg;
    logic [31:0] mem_data;
    logic [31:0] ex_data;
    logic [4:0]  wb_rd;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        fwd_we;
    logic [4:0]  fwd_rd;
    logic [31:0] fwd_data;
    logic [31:0] retired_count;

    int tests_run = 0;
    int tests_failed = 0;

    write_back_stage #(.DATA_W(32), .ADDR_W(5)) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .wb_valid      (wb_valid),
        .wb_reg_write  (wb_reg_write),
        .wb_mem_to_reg (wb_mem_to_reg),
        .mem_data      (mem_data),
        .ex_data       (ex_data),
        .wb_rd         (wb_rd),
        .rs_addr       (rs_addr),
        .rt_addr       (rt_addr),
        .rs_data       (rs_data),
        .rt_data       (rt_data),
        .fwd_we        (fwd_we),
        .fwd_rd        (fwd_rd),
        .fwd_data      (fwd_data),
        .retired_count (retired_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic rw, input logic m2r,
                         input logic [31:0] md, input logic [31:0] ed, input logic [4:0] rd);
        wb_valid      = v;
        wb_reg_write  = rw;
        wb_mem_to_reg = m2r;
        mem_data      = md;
        ex_data       = ed;
        wb_rd         = rd;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    endtask

    // One rising edge, returning at the following falling edge.
    task automatic step();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic read_rs(input logic [4:0] a, input logic [31:0] exp, input string tag);
        rs_addr = a;
        #0.05;
        check(tag, rs_data, exp);
    endtask

    initial begin
        reset_n = 1'b0;
        rs_addr = '0;
        rt_addr = '0;
        // A write presented while reset is held across edges must be lost.
        drive(1'b1, 1'b1, 1'b0, 32'h0, 32'h0000_00AA, 5'd9);
        #1;
        check("rst_fwd_we", {31'd0, fwd_we}, 32'd0);
        check("rst_count", retired_count, 32'd0);
        rs_addr = 5'd9;
        #1;
        check("rst_rs9", rs_data, 32'd0);
        @(posedge clock);
        @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        idle();
        step();
        read_rs(5'd9, 32'd0, "rst_write_lost");
        check("rst_count_after", retired_count, 32'd0);

        // Preload, then pulse reset between edges.
        drive(1'b1, 1'b1, 1'b0, 32'h0, 32'h0000_0011, 5'd1);
        step();
        drive(1'b1, 1'b1, 1'b1, 32'h0000_0022, 32'h0, 5'd2);
        step();
        idle();
        read_rs(5'd1, 32'h0000_0011, "preload_r1");
        read_rs(5'd2, 32'h0000_0022, "preload_r2");
        check("preload_count", retired_count, 32'd2);
        #0.5;
        reset_n = 1'b0;
        #0.2;
        for (int i = 0; i < 32; i++) begin
            read_rs(i[4:0], 32'd0, "pulse_rs");
        end
        check("pulse_count", retired_count, 32'd0);
        reset_n = 1'b1;
        @(negedge clock);

        // ALU write to r7; mem_data differs so the select is exercised.
        drive(1'b1, 1'b1, 1'b0, 32'h0000_0BAD, 32'h0000_1234, 5'd7);
        #0.1;
        check("alu_fwd_we", {31'd0, fwd_we}, 32'd1);
        check("alu_fwd_rd", {27'd0, fwd_rd}, 32'd7);
        check("alu_fwd_data", fwd_data, 32'h0000_1234);
        step();
        idle();
        read_rs(5'd7, 32'h0000_1234, "alu_r7");
        check("alu_count", retired_count, 32'd1);

        // Load write to r3 with both ports reading r3 in the same cycle.
        drive(1'b1, 1'b1, 1'b1, 32'hDEAD_BEEF, 32'h0000_5555, 5'd3);
        rs_addr = 5'd3;
        rt_addr = 5'd3;
        #0.1;
`ifdef WB_BYPASS_EN
        check("ld_rs_before", rs_data, 32'hDEAD_BEEF);
        check("ld_rt_before", rt_data, 32'hDEAD_BEEF);
`else
        check("ld_rs_before", rs_data, 32'h0);
        check("ld_rt_before", rt_data, 32'h0);
`endif
        check("ld_fwd_data", fwd_data, 32'hDEAD_BEEF);
        step();
        idle();
        #0.1;
        check("ld_rs_after", rs_data, 32'hDEAD_BEEF);
        check("ld_rt_after", rt_data, 32'hDEAD_BEEF);
        check("ld_count", retired_count, 32'd2);

        // Register 0 write is discarded.
        drive(1'b1, 1'b1, 1'b0, 32'h0, 32'hFFFF_FFFF, 5'd0);
        rs_addr = 5'd0;
        rt_addr = 5'd7;
        #0.1;
        check("r0_fwd_we", {31'd0, fwd_we}, 32'd0);
        check("r0_before", rs_data, 32'd0);
        check("r0_rt7", rt_data, 32'h0000_1234);
        step();
        idle();
        read_rs(5'd0, 32'd0, "r0_after");
        check("r0_count", retired_count, 32'd3);

        // Gating: set r5, then an invalid write, then a valid non-write.
        drive(1'b1, 1'b1, 1'b0, 32'h0, 32'h0000_0055, 5'd5);
        step();
        check("gate_count0", retired_count, 32'd4);
        drive(1'b0, 1'b1, 1'b0, 32'h0, 32'h0000_0099, 5'd5);
        #0.1;
        check("gate_fwd_we", {31'd0, fwd_we}, 32'd0);
        step();
        read_rs(5'd5, 32'h0000_0055, "gate_invalid_r5");
        check("gate_invalid_count", retired_count, 32'd4);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0000_0099, 5'd5);
        step();
        idle();
        read_rs(5'd5, 32'h0000_0055, "gate_nowrite_r5");
        check("gate_nowrite_count", retired_count, 32'd5);

        // Counter wrap.
        force dut.retired_count_q = 32'hFFFF_FFFF;
        #0.1;
        release dut.retired_count_q;
        #0.1;
        check("wrap_preset", retired_count, 32'hFFFF_FFFF);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
        step();
        idle();
        check("wrap_count", retired_count, 32'd0);
        step();
        check("wrap_hold", retired_count, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/write_back_stage.md
# write_back_stage

Final pipeline stage and architectural register file, downstream of `memory_access`. Takes the memory-stage results (load data, ALU result, destination register, write-back control), selects the write-back value, and commits it to a 32 x 32-bit register file on the rising clock edge. Provides two asynchronous read ports to the decode stage and exports the current write for the forwarding unit. Keeps a retired-instruction counter for bench and debug use.

## Interface
Parameters:
- `DATA_W`, 32: register and data width.
- `ADDR_W`, 5: register index width (32 registers).

Ports:
- `clock`  in  1  single clock; all state updates on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `wb_valid`  in  1  the memory stage holds a live instruction this cycle.
- `wb_reg_write`  in  1  the instruction writes a register (the memory stage's `wb_salida`).
- `wb_mem_to_reg`  in  1  select for the write value: 1 = `mem_data`, 0 = `ex_data`.
- `mem_data`  in  DATA_W  load data from the memory stage.
- `ex_data`  in  DATA_W  ALU result passed through the memory stage.
- `wb_rd`  in  ADDR_W  destination register index.
- `rs_addr`, `rt_addr`  in  ADDR_W  decode-stage read indices.
- `rs_data`, `rt_data`  out  DATA_W  read data, combinational.
- `fwd_we`  out  1  a register write is being committed this cycle.
- `fwd_rd`  out  ADDR_W  destination index of that write.
- `fwd_data`  out  DATA_W  value of that write.
- `retired_count`  out  32  count of valid instructions retired.

## Operation
- Write value: `wdata = wb_mem_to_reg ? mem_data : ex_data`.
- Commit enable: `we = wb_valid & wb_reg_write & (wb_rd != 0)`.
- On a rising edge with `we` = 1, `regs[wb_rd] <= wdata`.
- Register 0 is hardwired to zero. Writes to it are discarded, and reads of it always return 0, including through the bypass path.
- `fwd_we = we`, `fwd_rd = wb_rd`, `fwd_data = wdata`. All three are combinational.
- `retired_count` increments by 1 on every edge where `wb_valid` = 1, whether or not the instruction writes a register.
- `retired_count` wraps from 0xFFFFFFFF to 0 with no flag.
- Read ports are asynchronous muxes over `regs`. The optional bypass is described under Configuration.
- Both read ports may address the same register, or the same register as the write, in the same cycle. Each port resolves independently.

## Timing
- Reset:
  - On `reset_n` low, all 32 registers and `retired_count` clear to 0 immediately, with no clock required.
  - While reset is asserted, `rs_data` and `rt_data` read 0 and edges are ignored.
  - `fwd_*` stay combinational but `fwd_we` is forced to 0 during reset.
- Reset released mid-stream: the first edge after `reset_n` rises commits normally. Any write presented during reset is lost.
- Write latency: data is visible on a read port 1 cycle after the commit edge. With bypass it is visible in the same cycle.
- Read latency: 0 cycles, combinational from `rs_addr`/`rt_addr`.
- This stage has no stall input. The memory stage is responsible for presenting `wb_valid` = 0 for bubbles.

## Configuration
- Macro `WB_BYPASS_EN`.
- Defined: write-first bypass. When `we` = 1 and `rs_addr == wb_rd`, `rs_data = wdata` in the same cycle. Likewise for `rt`.
- Not defined: read ports return stored contents only. Decode sees the new value one cycle after the commit edge, and the hazard unit must stall or forward from `fwd_*`.

## Test plan
- Reset: preload registers with writes, then pulse `reset_n` low with no clock edge. Required: every `rs_data` read returns 0 and `retired_count` = 0.
- ALU write: `wb_valid`=1, `wb_reg_write`=1, `wb_mem_to_reg`=0, `ex_data`=0x0000_1234, `wb_rd`=7. Required: after the edge, `rs_addr`=7 reads 0x0000_1234 and `retired_count` = 1.
- Load write with bypass: `wb_mem_to_reg`=1, `mem_data`=0xDEAD_BEEF, `wb_rd`=3, `rs_addr`=`rt_addr`=3 in the same cycle.
  - With `WB_BYPASS_EN`: both ports read 0xDEAD_BEEF before the edge.
  - Without it: both ports read the old value before the edge and 0xDEAD_BEEF after it.
- Register 0: write 0xFFFF_FFFF to `wb_rd`=0. Required: `fwd_we`=0, and `rs_addr`=0 reads 0 both before and after the edge.
- Gating: `wb_valid`=0, `wb_reg_write`=1, `wb_rd`=5. Required: register 5 is unchanged and `retired_count` does not increment. Then `wb_valid`=1, `wb_reg_write`=0. Required: register 5 is still unchanged and `retired_count` increments by 1.
- Counter wrap: force `retired_count` to 0xFFFF_FFFF, then one valid edge. Required: `retired_count` = 0.
